// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed 7-segment driver: frame-coherent digit shadows,
// per-slot anode blanking, optional leading-zero blanking and blink.
module seg7_scan_2digit #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned LZB            = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dv,
  input  logic [3:0] ch,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]  AN_OFF  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic [BLK_W-1:0] r_blank_cnt;
  logic [FRM_W-1:0] r_frm_cnt;
  logic             r_phase;
  logic [3:0]       r_dv_q;
  logic [3:0]       r_ch_q;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;

  logic             w_tick;
  logic             w_frame_end;
  logic             w_dark;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_hi;
  logic [1:0]       w_an_hi;
  logic [6:0]       w_seg;
  logic [1:0]       w_an;

  // Slot timing, digit select and active-high decode
  always_comb begin
    w_tick      = (r_cnt == CNT_W'(SCAN_DIV - 1));
    w_frame_end = w_tick && r_sel;
    w_digit     = r_sel ? r_ch_q : r_dv_q;
    case (w_digit)
      4'd0:    w_seg_hi = 7'h3F;
      4'd1:    w_seg_hi = 7'h06;
      4'd2:    w_seg_hi = 7'h5B;
      4'd3:    w_seg_hi = 7'h4F;
      4'd4:    w_seg_hi = 7'h66;
      4'd5:    w_seg_hi = 7'h6D;
      4'd6:    w_seg_hi = 7'h7D;
      4'd7:    w_seg_hi = 7'h07;
      4'd8:    w_seg_hi = 7'h7F;
      4'd9:    w_seg_hi = 7'h6F;
      default: w_seg_hi = 7'h40;
    endcase
    w_dark  = (r_blank_cnt != '0) || (blink && r_phase) ||
              ((LZB != 0) && r_sel && (r_ch_q == 4'd0));
    w_an_hi = r_sel ? 2'b10 : 2'b01;
    w_seg   = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
    if (w_dark) begin
      w_an = AN_OFF;
    end else begin
      w_an = (AN_ACTIVE_LOW != 0) ? ~w_an_hi : w_an_hi;
    end
  end

  // Scan state, shadows and blink phase; outputs lag state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_blank_cnt <= BLK_W'(BLANK_CYC);
      r_frm_cnt   <= '0;
      r_phase     <= 1'b0;
      r_dv_q      <= 4'd9;
      r_ch_q      <= 4'd9;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
      if (w_tick) begin
        r_cnt       <= '0;
        r_sel       <= ~r_sel;
        r_blank_cnt <= BLK_W'(BLANK_CYC);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_blank_cnt != '0) begin
          r_blank_cnt <= r_blank_cnt - BLK_W'(1);
        end
      end
      // Both digits of a frame come from one sample
      if (w_frame_end) begin
        r_dv_q <= dv;
        r_ch_q <= ch;
      end
      if (!blink) begin
        r_frm_cnt <= '0;
        r_phase   <= 1'b0;
      end else if (w_frame_end) begin
        if (r_frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          r_frm_cnt <= '0;
          r_phase   <= ~r_phase;
        end else begin
          r_frm_cnt <= r_frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Bench for seg7_scan_2digit: cycle model from slot arithmetic plus directed
// literal checks; two instances differ only in leading-zero blanking.
module tb_seg7_scan_2digit;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic       clk;
  logic       reset;
  logic [3:0] dv;
  logic [3:0] ch;
  logic       blink;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;

  int n_total = 0;
  int n_bad   = 0;

  seg7_scan_2digit #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZB(0)
  ) u_dut (
    .clk(clk), .reset(reset), .dv(dv), .ch(ch), .blink(blink),
    .seg(seg0), .an(an0)
  );

  seg7_scan_2digit #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZB(1)
  ) u_dut_lzb (
    .clk(clk), .reset(reset), .dv(dv), .ch(ch), .blink(blink),
    .seg(seg1), .an(an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset, frames seen while blinking, shadows
  int         m_n;
  int         m_bf;
  int         m_pos;
  bit         m_tens;
  bit         m_ph;
  bit         m_dark;
  bit         m_valid = 0;
  bit         e_rst;
  logic [3:0] m_dv, m_ch;
  logic [1:0] e_an0, e_an1;
  logic [6:0] e_seg;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      e_rst   = 1;
      e_an0   = 2'b11;
      e_an1   = 2'b11;
      e_seg   = 7'h7F;
      m_n     = 0;
      m_bf    = 0;
      m_dv    = 4'd9;
      m_ch    = 4'd9;
    end else if (m_valid) begin
      m_pos  = m_n % SD;
      m_tens = ((m_n / SD) % 2) == 1;
      m_ph   = ((m_bf / BF) % 2) == 1;
      e_rst  = 0;
      e_seg  = ~SEG_TBL[m_tens ? m_ch : m_dv];
      m_dark = (m_pos < BC) || (blink && m_ph);
      e_an0  = m_dark ? 2'b11 : (m_tens ? 2'b01 : 2'b10);
      e_an1  = (m_dark || (m_tens && m_ch == 4'd0)) ? 2'b11 : e_an0;
      if (!blink) m_bf = 0;
      else if (m_pos == SD - 1 && m_tens) m_bf++;
      if (m_pos == SD - 1 && m_tens) begin
        m_dv = dv;
        m_ch = ch;
      end
      m_n++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("an_model", an0, e_an0);
      chk("an_lzb_model", an1, e_an1);
      chk("an_not_both_on", an0 == 2'b00, 0);
      chk("an_lzb_not_both_on", an1 == 2'b00, 0);
      if (e_rst || e_an0 != 2'b11) chk("seg_model", seg0, e_seg);
      if (e_rst || e_an1 != 2'b11) chk("seg_lzb_model", seg1, e_seg);
    end
  end

  task automatic wait_an(input string name, input bit lzb, input logic [1:0] tgt, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((lzb ? an1 : an0) == tgt) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(name, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run, maxrun, c01, c10, c01_lzb, c10_lzb;
    bit lit;
    reset = 1'b1; dv = 4'd3; ch = 4'd7; blink = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an0, 2'b11);
    chk("rst_seg", seg0, 7'h7F);
    chk("rst_lzb_an", an1, 2'b11);
    reset = 1'b0;

    // Shadows hold 9 until the first frame end
    wait_an("to_units0", 0, 2'b10, 12);
    chk("post_rst_units9", seg0, 7'h10);
    wait_an("to_tens0", 0, 2'b01, 12);
    chk("post_rst_tens9", seg0, 7'h10);
    dv = 4'd2; ch = 4'd5;

    wait_an("to_units1", 0, 2'b10, 12);
    chk("units_2", seg0, 7'h24);
    wait_an("to_tens1", 0, 2'b01, 12);
    chk("tens_5", seg0, 7'h12);

    // Mid-slot change must not tear the current frame
    wait_an("to_units2", 0, 2'b10, 12);
    dv = 4'd1;
    wait_an("to_tens2", 0, 2'b01, 12);
    chk("no_tear_tens5", seg0, 7'h12);
    wait_an("to_units3", 0, 2'b10, 12);
    chk("units_1", seg0, 7'h79);

    dv = 4'hC;
    wait_an("to_tens3", 0, 2'b01, 12);
    wait_an("to_units4", 0, 2'b10, 12);
    chk("units_dash", seg0, 7'h3F);

    dv = 4'd7; ch = 4'd0;
    wait_an("to_tens4", 0, 2'b01, 12);
    wait_an("to_units5", 0, 2'b10, 12);
    chk("units_7", seg0, 7'h78);
    chk("lzb_units_7", seg1, 7'h78);
    c01 = 0; c10 = 0; c01_lzb = 0; c10_lzb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an0 == 2'b01) c01++;
      if (an0 == 2'b10) c10++;
      if (an1 == 2'b01) c01_lzb++;
      if (an1 == 2'b10) c10_lzb++;
    end
    chk("tens0_lit_cnt", c01, 6);
    chk("units_lit_cnt", c10, 6);
    chk("lzb_tens_dark_cnt", c01_lzb, 0);
    chk("lzb_units_lit_cnt", c10_lzb, 6);

    // Blink: 2 frames lit, 2 dark; dark run includes next slot's blank cycle
    blink = 1'b1;
    run = 0; maxrun = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (an0 == 2'b11) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("blink_dark_run", maxrun, 17);

    run = 0;
    for (int i = 0; i < 100 && run < 5; i++) begin
      @(negedge clk);
      run = (an0 == 2'b11) ? run + 1 : 0;
    end
    chk("blink_dark_found", run >= 5, 1);
    blink = 1'b0;
    lit = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (an0 != 2'b11) lit = 1;
    end
    chk("blink_drop_resume", lit, 1);

    // Reset mid-slot blanks on the very next edge
    wait_an("to_units_lzb", 1, 2'b10, 12);
    reset = 1'b1;
    @(negedge clk);
    chk("midslot_rst_an", an0, 2'b11);
    chk("midslot_rst_lzb_an", an1, 2'b11);
    chk("midslot_rst_seg", seg0, 7'h7F);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
